// File: rtl/arch_state_reg_pkg.sv
// ---------------------------------------------------------------------------
// arch_state_reg_pkg
// Shared definitions for the architectural-state register block:
//   - packed slot offsets of the ten 32-bit registers inside the 320-bit state
//   - register selectors (REG_*)
//   - EFLAGS reserved-bit mask (bit 1 always reads as one)
//   - FSM state encodings
//   - helper that applies the EFLAGS reserved bit to a captured state
// ---------------------------------------------------------------------------
package arch_state_reg_pkg;

    localparam int ARCH_STATE_W = 320;
    localparam int ARCH_REG_W   = 32;

    // Slot offsets within the packed state vector
    localparam int EAX_OFF    = 0;
    localparam int EBX_OFF    = 32;
    localparam int ECX_OFF    = 64;
    localparam int EDX_OFF    = 96;
    localparam int ESI_OFF    = 128;
    localparam int EDI_OFF    = 160;
    localparam int ESP_OFF    = 192;
    localparam int EBP_OFF    = 224;
    localparam int EIP_OFF    = 256;
    localparam int EFLAGS_OFF = 288;

    // EFLAGS bit 1 is architecturally reserved and always set
    localparam logic [31:0] EFLAGS_RSVD_MASK = 32'h0000_0002;

    typedef enum logic [3:0] {
        REG_EAX    = 4'd0,
        REG_EBX    = 4'd1,
        REG_ECX    = 4'd2,
        REG_EDX    = 4'd3,
        REG_ESI    = 4'd4,
        REG_EDI    = 4'd5,
        REG_ESP    = 4'd6,
        REG_EBP    = 4'd7,
        REG_EIP    = 4'd8,
        REG_EFLAGS = 4'd9
    } reg_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    // Force the EFLAGS reserved bit on a state about to be stored
    function automatic logic [ARCH_STATE_W-1:0] apply_flags_rsvd(
        input logic [ARCH_STATE_W-1:0] s
    );
        logic [ARCH_STATE_W-1:0] r;
        r = s;
        r[EFLAGS_OFF +: ARCH_REG_W] = s[EFLAGS_OFF +: ARCH_REG_W] | EFLAGS_RSVD_MASK;
        return r;
    endfunction

    // State value right after reset: all zero except the reserved flag
    function automatic logic [ARCH_STATE_W-1:0] reset_state();
        logic [ARCH_STATE_W-1:0] r;
        r = '0;
        r[EFLAGS_OFF +: ARCH_REG_W] = EFLAGS_RSVD_MASK;
        return r;
    endfunction

endpackage

// File: rtl/arch_state_reg_step_counter.sv
// ---------------------------------------------------------------------------
// step_counter
// Saturating step counter with a limit latched at clear time.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr            clear count to zero and latch limit_in
//   inc            count one completed step (saturates at all-ones)
//   limit_in       step limit offered at clear (0 = unbounded)
//   cnt            completed-step count
//   hit            the increment requested this cycle lands on the limit
// ---------------------------------------------------------------------------
module step_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit_in,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] limit_r;
    logic [CNT_W-1:0] cnt_inc_s;

    // Saturating increment and terminal compare against the latched limit
    always_comb begin
        cnt_inc_s = cnt_r;
        hit       = 1'b0;
        if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_inc_s = cnt_r;
        end
        if (limit_r != {CNT_W{1'b0}}) begin
            hit = (cnt_inc_s == limit_r);
        end else begin
            hit = 1'b0;
        end
    end

    // Count and limit registers; clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            limit_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r   <= {CNT_W{1'b0}};
            limit_r <= limit_in;
        end else if (inc) begin
            cnt_r   <= cnt_inc_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/arch_state_reg.sv
// ---------------------------------------------------------------------------
// arch_state_reg
// Holds the packed x86 architectural state (EAX..EFLAGS) across steps.
// Loads an initial state, presents it downstream, waits for the register
// file's next state, and repeats until step_limit steps complete.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_valid/ready/state    initial state handshake
//   step_limit                steps to run (0 = unbounded), sampled at load
//   abort                     return to IDLE, keeping state and count
//   cur_valid/ready/state     current state to decode/execute
//   nxt_valid/ready/state     next state from the register file
//   step_cnt                  completed steps (saturating)
//   halted                    step limit reached
// ---------------------------------------------------------------------------
module arch_state_reg
    import arch_state_reg_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int STATE_W = 320
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [STATE_W-1:0] load_state,
    input  logic [CNT_W-1:0]   step_limit,
    input  logic               abort,
    output logic               cur_valid,
    input  logic               cur_ready,
    output logic [STATE_W-1:0] cur_state,
    input  logic               nxt_valid,
    output logic               nxt_ready,
    input  logic [STATE_W-1:0] nxt_state,
    output logic [CNT_W-1:0]   step_cnt,
    output logic               halted
);

    fsm_state_e         state_r;
    logic [STATE_W-1:0] cur_state_r;
    logic               load_ready_r;
    logic               cur_valid_r;
    logic               nxt_ready_r;
    logic               halted_r;
    logic               load_take_s;
    logic               nxt_take_s;
    logic               hit_s;

    // Handshake acceptance; abort suppresses both captures
    always_comb begin
        load_take_s = 1'b0;
        nxt_take_s  = 1'b0;
        if (!abort) begin
            load_take_s = load_valid && ((state_r == ST_IDLE) || (state_r == ST_DONE));
            nxt_take_s  = nxt_valid && (state_r == ST_WAIT);
        end else begin
            load_take_s = 1'b0;
            nxt_take_s  = 1'b0;
        end
    end

    step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (load_take_s),
        .inc      (nxt_take_s),
        .limit_in (step_limit),
        .cnt      (step_cnt),
        .hit      (hit_s)
    );

    // Step FSM with registered handshake outputs and state capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cur_state_r  <= reset_state();
            load_ready_r <= 1'b1;
            cur_valid_r  <= 1'b0;
            nxt_ready_r  <= 1'b0;
            halted_r     <= 1'b0;
        end else if (abort) begin
            state_r      <= ST_IDLE;
            load_ready_r <= 1'b1;
            cur_valid_r  <= 1'b0;
            nxt_ready_r  <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (load_valid) begin
                        state_r      <= ST_RUN;
                        cur_state_r  <= apply_flags_rsvd(load_state);
                        load_ready_r <= 1'b0;
                        cur_valid_r  <= 1'b1;
                        nxt_ready_r  <= 1'b0;
                        halted_r     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cur_ready) begin
                        state_r     <= ST_WAIT;
                        cur_valid_r <= 1'b0;
                        nxt_ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (nxt_valid) begin
                        cur_state_r <= apply_flags_rsvd(nxt_state);
                        nxt_ready_r <= 1'b0;
                        if (hit_s) begin
                            state_r      <= ST_DONE;
                            halted_r     <= 1'b1;
                            load_ready_r <= 1'b1;
                        end else begin
                            state_r     <= ST_RUN;
                            cur_valid_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    load_ready_r <= 1'b1;
                    cur_valid_r  <= 1'b0;
                    nxt_ready_r  <= 1'b0;
                    halted_r     <= 1'b0;
                end
            endcase
        end
    end

    assign cur_state  = cur_state_r;
    assign load_ready = load_ready_r;
    assign cur_valid  = cur_valid_r;
    assign nxt_ready  = nxt_ready_r;
    assign halted     = halted_r;

endmodule

// File: doc/arch_state_reg.md
ARCH_STATE_REG -- requirements
Module: arch_state_reg

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the step counter and step limit width.
REQ-002 Parameter STATE_W, default 320, SHALL set the packed architectural-state width (10 x 32 bits) and is fixed at 320.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_valid  input  1  initial state offered.
REQ-006 load_ready  output  1  initial state accepted this cycle when high with load_valid.
REQ-007 load_state  input  320  initial EAX..EFLAGS, packed per REQ-016.
REQ-008 step_limit  input  CNT_W  number of steps to run; 0 means unbounded.
REQ-009 abort  input  1  discard the run and return to IDLE.
REQ-010 cur_valid  output  1  cur_state is live and feeds decode/execute and the register file's i_* inputs.
REQ-011 cur_ready  input  1  downstream consumed cur_state.
REQ-012 cur_state  output  320  current architectural state, packed per REQ-016.
REQ-013 nxt_valid  input  1  register-file outputs (o_*) for the step are valid.
REQ-014 nxt_ready  output  1  block accepts nxt_state.
REQ-015 nxt_state  input  320  next architectural state, packed per REQ-016.
REQ-016 Packing SHALL be EAX[31:0], EBX[63:32], ECX[95:64], EDX[127:96], ESI[159:128], EDI[191:160], ESP[223:192], EBP[255:224], EIP[287:256], EFLAGS[319:288].
REQ-017 step_cnt  output  CNT_W  number of completed steps.
REQ-018 halted  output  1  step_limit was reached.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, RUN, WAIT and DONE.
REQ-020 IDLE: load_ready=1, cur_valid=0, nxt_ready=0; on load_valid, capture load_state, clear step_cnt and go to RUN.
REQ-021 RUN: cur_valid=1; on cur_ready, go to WAIT; cur_state SHALL be held stable while cur_valid=1.
REQ-022 WAIT: cur_valid=0, nxt_ready=1; on nxt_valid, capture nxt_state and increment step_cnt.
REQ-023 From WAIT on capture, go to DONE if step_limit!=0 and the incremented count equals step_limit; otherwise go to RUN.
REQ-024 DONE: halted=1, load_ready=1, cur_valid=0; cur_state SHALL hold the final state.
REQ-025 In DONE, load_valid SHALL act as in IDLE (reload, clear count, go to RUN).
REQ-026 load_ready SHALL be 0 in RUN and WAIT; load_valid in those states SHALL be ignored.
REQ-027 Every capture (load or next) SHALL force EFLAGS bit 1 to 1; all other bits SHALL be stored verbatim.
REQ-028 Latency SHALL be one cycle: a capture at edge N is visible on cur_state after edge N, and cur_valid SHALL rise in that same cycle.
REQ-029 With step_limit=0, step_cnt SHALL saturate at all-ones and SHALL NOT wrap; the block SHALL stay in RUN/WAIT.
REQ-030 abort SHALL force IDLE on the next edge from any state; cur_state and step_cnt SHALL hold; abort SHALL win over a simultaneous load or nxt capture.
REQ-031 step_limit SHALL be sampled at load; changes mid-run SHALL have no effect.
REQ-032 nxt_valid outside WAIT SHALL be ignored.

Reset
REQ-033 On rst: state=IDLE, cur_state=0 except EFLAGS=0x00000002, step_cnt=0, halted=0, cur_valid=0, nxt_ready=0, load_ready=1 in the following cycle.
REQ-034 rst SHALL take priority over abort, load_valid and nxt_valid, including mid-run.

Structure
REQ-035 The state slot offsets, the EFLAGS reserved-bit mask and the FSM encodings SHALL live in the shared defines file alongside the REG_* selectors.
REQ-036 One sub-module, step_counter (saturating, clear, increment, compare against the latched limit, terminal flag), SHALL be instantiated; all other logic SHALL be inline.

Verification
REQ-037 rst, then load with EAX=0x11111111, EFLAGS=0 and limit 1 -> next cycle cur_valid=1, EAX=0x11111111, EFLAGS=0x00000002.
REQ-038 limit=3, cur_ready every RUN cycle, nxt_valid after 2 cycles in WAIT -> step_cnt goes 1, 2, 3, then halted=1 with cur_state equal to the 3rd nxt_state.
REQ-039 abort asserted in the same cycle as nxt_valid in WAIT -> IDLE, step_cnt unchanged, nxt_state discarded.
REQ-040 CNT_W=4, limit=0, 20 steps -> step_cnt sticks at 15, halted=0.
REQ-041 load_valid pulsed during RUN -> load_ready=0 and cur_state unchanged; load_valid in DONE -> reload, step_cnt=0, RUN.
REQ-042 rst asserted in WAIT -> REQ-033 values next cycle, and nxt_valid in that cycle is ignored.
